// File: rtl/idu_is_biq_ctrl.sv
// Branch issue queue scheduler: allocates free entries, tracks relative age with
// an age matrix and issues the oldest ready entry to the branch pipe each cycle.
module idu_is_biq_ctrl #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst_clk,
    input  logic               rtu_global_flush,
    input  logic               dispatch_vld,
    output logic               dispatch_accept,
    output logic               biq_full,
    output logic [ENTRIES-1:0] create_vld_oh,
    input  logic [ENTRIES-1:0] entry_vld,
    input  logic [ENTRIES-1:0] entry_ready,
    input  logic               bju_stall,
    output logic               issue_vld,
    output logic [ENTRIES-1:0] issue_vld_oh,
    output logic [IDX_W-1:0]   issue_idx,
    output logic [IDX_W:0]     entry_cnt
);

    // age[i][j] = 1 means entry i is older than entry j
    logic [ENTRIES-1:0][ENTRIES-1:0] age;
    logic [ENTRIES-1:0]              free_vec;
    logic [ENTRIES-1:0]              target_oh;
    logic [ENTRIES-1:0]              older_rdy;
    logic [ENTRIES-1:0]              cand;
    logic [IDX_W:0]                  cnt_nxt;

    assign free_vec        = ~entry_vld;
    assign target_oh       = free_vec & (~free_vec + ENTRIES'(1));
    assign dispatch_accept = dispatch_vld & ~biq_full & ~rtu_global_flush;
    assign create_vld_oh   = dispatch_accept ? target_oh : '0;

    // An entry is a candidate when no ready entry is older than it; stale age
    // bits of invalid entries are masked by entry_ready.
    always_comb begin
        older_rdy = '0;
        cand      = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            for (int j = 0; j < ENTRIES; j++) begin
                older_rdy[i] = older_rdy[i] | (entry_ready[j] & age[j][i]);
            end
            cand[i] = entry_ready[i] & ~older_rdy[i];
        end
    end

    assign issue_vld_oh = cand & {ENTRIES{~bju_stall & ~rtu_global_flush}};
    assign issue_vld    = |issue_vld_oh;

    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (issue_vld_oh[i]) begin
                issue_idx = issue_idx | IDX_W'(i);
            end
        end
    end

    assign cnt_nxt = entry_cnt + (IDX_W+1)'(dispatch_accept) - (IDX_W+1)'(issue_vld);

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            entry_cnt <= '0;
            biq_full  <= 1'b0;
        end else if (rtu_global_flush) begin
            entry_cnt <= '0;
            biq_full  <= 1'b0;
        end else begin
            entry_cnt <= cnt_nxt;
            biq_full  <= (cnt_nxt == (IDX_W+1)'(ENTRIES));
        end
    end

    // A new entry is younger than every entry that stays valid past this edge.
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            age <= '0;
        end else if (rtu_global_flush) begin
            age <= '0;
        end else if (dispatch_accept) begin
            for (int k = 0; k < ENTRIES; k++) begin
                if (create_vld_oh[k]) begin
                    age[k] <= '0;
                    for (int j = 0; j < ENTRIES; j++) begin
                        if (j != k) begin
                            age[j][k] <= entry_vld[j] & ~issue_vld_oh[j];
                        end
                    end
                end
            end
        end
    end

    a_issue_onehot: assert property (@(posedge clk) disable iff (!rst_clk)
        $onehot0(issue_vld_oh));
    a_create_onehot: assert property (@(posedge clk) disable iff (!rst_clk)
        $onehot0(create_vld_oh));
    a_create_free: assert property (@(posedge clk) disable iff (!rst_clk)
        (create_vld_oh & entry_vld) == '0);
    a_cnt_match: assert property (@(posedge clk) disable iff (!rst_clk)
        $countones(entry_vld) == int'(entry_cnt));

endmodule

// File: tb/tb_idu_is_biq_ctrl.sv
// Directed self-checking bench for idu_is_biq_ctrl with a behavioural model of the
// BIQ entries (set on create, cleared on issue or flush).
module tb_idu_is_biq_ctrl;

    localparam int ENTRIES = 8;
    localparam int IDX_W   = 3;

    typedef struct {
        logic       dv;
        logic [7:0] src;
        logic       stall;
        logic       flush;
        logic       exp_acc;
        logic [7:0] exp_cre;
        logic [7:0] exp_iss;
        logic [2:0] exp_idx;
        logic [3:0] exp_cnt;
        logic       exp_full;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_clk;
    logic               rtu_global_flush;
    logic               dispatch_vld;
    logic               dispatch_accept;
    logic               biq_full;
    logic [ENTRIES-1:0] create_vld_oh;
    logic [ENTRIES-1:0] ent_vld;
    logic [ENTRIES-1:0] entry_ready;
    logic [ENTRIES-1:0] src_rdy;
    logic               bju_stall;
    logic               issue_vld;
    logic [ENTRIES-1:0] issue_vld_oh;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W:0]     entry_cnt;

    int n_total = 0;
    int n_pass  = 0;

    vec_t fill_tbl[9];
    vec_t age_tbl[6];

    always #5 clk = ~clk;

    idu_is_biq_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst_clk          (rst_clk),
        .rtu_global_flush (rtu_global_flush),
        .dispatch_vld     (dispatch_vld),
        .dispatch_accept  (dispatch_accept),
        .biq_full         (biq_full),
        .create_vld_oh    (create_vld_oh),
        .entry_vld        (ent_vld),
        .entry_ready      (entry_ready),
        .bju_stall        (bju_stall),
        .issue_vld        (issue_vld),
        .issue_vld_oh     (issue_vld_oh),
        .issue_idx        (issue_idx),
        .entry_cnt        (entry_cnt)
    );

    // Entry model: ready only when valid and both sources are ready
    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            ent_vld <= '0;
        end else if (rtu_global_flush) begin
            ent_vld <= '0;
        end else begin
            ent_vld <= (ent_vld & ~issue_vld_oh) | create_vld_oh;
        end
    end

    assign entry_ready = ent_vld & src_rdy;

    function automatic vec_t mk(input logic dv, input logic [7:0] src, input logic stall,
                                input logic flush, input logic acc, input logic [7:0] cre,
                                input logic [7:0] iss, input logic [2:0] idx,
                                input logic [3:0] cnt, input logic full);
        vec_t v;
        v.dv = dv; v.src = src; v.stall = stall; v.flush = flush;
        v.exp_acc = acc; v.exp_cre = cre; v.exp_iss = iss; v.exp_idx = idx;
        v.exp_cnt = cnt; v.exp_full = full;
        return v;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic acc, input logic [7:0] cre,
                                input logic [7:0] iss, input logic [2:0] idx,
                                input logic [3:0] cnt, input logic full);
        check_eq({tag, " dispatch_accept"}, 32'(dispatch_accept), 32'(acc));
        check_eq({tag, " create_vld_oh"},   32'(create_vld_oh),   32'(cre));
        check_eq({tag, " issue_vld"},       32'(issue_vld),       32'(|iss));
        check_eq({tag, " issue_vld_oh"},    32'(issue_vld_oh),    32'(iss));
        check_eq({tag, " issue_idx"},       32'(issue_idx),       32'(idx));
        check_eq({tag, " entry_cnt"},       32'(entry_cnt),       32'(cnt));
        check_eq({tag, " biq_full"},        32'(biq_full),        32'(full));
    endtask

    task automatic apply_stimulus(input logic dv, input logic [7:0] src,
                                  input logic stall, input logic flush);
        @(posedge clk);
        #1;
        dispatch_vld     = dv;
        src_rdy          = src;
        bju_stall        = stall;
        rtu_global_flush = flush;
        @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        apply_stimulus(v.dv, v.src, v.stall, v.flush);
        check_output(tag, v.exp_acc, v.exp_cre, v.exp_iss, v.exp_idx, v.exp_cnt, v.exp_full);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Fill from empty: entries 0..7 in order, then the 9th request is refused
        for (int i = 0; i < 8; i++) begin
            fill_tbl[i] = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'(1 << i), 8'h00, 3'd0, 4'(i), 1'b0);
        end
        fill_tbl[8] = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 4'd8, 1'b1);

        // Create 0,1,2 then ready 1 and 2 together: older entry 1 issues first
        age_tbl[0] = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 3'd0, 4'd0, 1'b0);
        age_tbl[1] = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 8'h00, 3'd0, 4'd1, 1'b0);
        age_tbl[2] = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h04, 8'h00, 3'd0, 4'd2, 1'b0);
        age_tbl[3] = mk(1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 3'd1, 4'd3, 1'b0);
        age_tbl[4] = mk(1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 3'd2, 4'd2, 1'b0);
        age_tbl[5] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 4'd1, 1'b0);

        rst_clk          = 1'b0;
        dispatch_vld     = 1'b0;
        src_rdy          = '0;
        bju_stall        = 1'b0;
        rtu_global_flush = 1'b0;
        #1;
        check_output("reset", 1'b0, 8'h00, 8'h00, 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_clk = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec($sformatf("fill[%0d]", i), fill_tbl[i]);
        end

        // Issue entry 0 from full; it is reallocated next cycle as the youngest
        apply_stimulus(1'b1, 8'h01, 1'b0, 1'b0);
        check_output("realloc issue0", 1'b0, 8'h00, 8'h01, 3'd0, 4'd8, 1'b1);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0);
        check_output("realloc create0", 1'b1, 8'h01, 8'h00, 3'd0, 4'd7, 1'b0);
        apply_stimulus(1'b0, 8'h05, 1'b0, 1'b0);
        check_output("realloc older2", 1'b0, 8'h00, 8'h04, 3'd2, 4'd8, 1'b1);
        apply_stimulus(1'b0, 8'h05, 1'b0, 1'b0);
        check_output("realloc young0", 1'b0, 8'h00, 8'h01, 3'd0, 4'd7, 1'b0);
        apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        check_output("flush A", 1'b0, 8'h00, 8'h00, 3'd0, 4'd6, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("after flush A", 1'b0, 8'h00, 8'h00, 3'd0, 4'd0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("age[%0d]", i), age_tbl[i]);
        end

        // Stall with entry 3 ready: held until the stall drops
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0);
        check_output("stall create1", 1'b1, 8'h02, 8'h00, 3'd0, 4'd1, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0);
        check_output("stall create2", 1'b1, 8'h04, 8'h00, 3'd0, 4'd2, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0);
        check_output("stall create3", 1'b1, 8'h08, 8'h00, 3'd0, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 8'h08, 1'b1, 1'b0);
            check_output($sformatf("stall[%0d]", i), 1'b0, 8'h00, 8'h00, 3'd0, 4'd4, 1'b0);
        end
        apply_stimulus(1'b0, 8'h08, 1'b0, 1'b0);
        check_output("stall release", 1'b0, 8'h00, 8'h08, 3'd3, 4'd4, 1'b0);

        // Build cnt=5, then simultaneous create and issue, then flush
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0);
        check_output("cnt create3", 1'b1, 8'h08, 8'h00, 3'd0, 4'd3, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0);
        check_output("cnt create4", 1'b1, 8'h10, 8'h00, 3'd0, 4'd4, 1'b0);
        apply_stimulus(1'b1, 8'h01, 1'b0, 1'b0);
        check_output("create+issue", 1'b1, 8'h20, 8'h01, 3'd0, 4'd5, 1'b0);
        apply_stimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        check_output("flush B", 1'b0, 8'h00, 8'h00, 3'd0, 4'd5, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("after flush B", 1'b0, 8'h00, 8'h00, 3'd0, 4'd0, 1'b0);

        // Async reset mid-fill at cnt=4
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0);
            check_output($sformatf("midfill[%0d]", i), 1'b1, 8'(1 << i), 8'h00, 3'd0, 4'(i), 1'b0);
        end
        @(posedge clk);
        #1;
        check_eq("cnt before reset", 32'(entry_cnt), 32'd4);
        dispatch_vld = 1'b0;
        src_rdy      = '0;
        rst_clk      = 1'b0;
        #1;
        check_output("async reset", 1'b0, 8'h00, 8'h00, 3'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_clk = 1'b1;
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0);
        check_output("post reset create0", 1'b1, 8'h01, 8'h00, 3'd0, 4'd0, 1'b0);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0);
        check_output("post reset create1", 1'b1, 8'h02, 8'h00, 3'd0, 4'd1, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
